// File: rtl/transpose_addr_seq.sv
// Chunk-walking address sequencer for matrix copy / transpose.
// Emits one source/destination row-address pair per chunk row over a
// valid/ready stream, with abort, backpressure and a done pulse.
module transpose_addr_seq #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ARR_ROWS   = 8,
    parameter int unsigned ARR_COLS   = 8,
    parameter int unsigned CHUNK_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic                  abort,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic [ADDR_WIDTH-1:0] src_addr,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  chunk_last,
    output logic                  pass_last,
    output logic                  busy,
    output logic                  done
);

    // Geometry; element size and all matrix dimensions are powers of two,
    // so every product reduces to a shift.
    localparam int unsigned EB     = DATA_WIDTH / 8;
    localparam int unsigned CR     = ARR_ROWS / CHUNK_SIZE;
    localparam int unsigned CC     = ARR_COLS / CHUNK_SIZE;
    localparam int unsigned LOG_EB = $clog2(EB);
    localparam int unsigned LOG_CS = $clog2(CHUNK_SIZE);
    localparam int unsigned LOG_SP = $clog2(ARR_COLS) + LOG_EB;
    localparam int unsigned LOG_TP = $clog2(ARR_ROWS) + LOG_EB;
    localparam int unsigned LOG_CB = LOG_CS + LOG_EB;
    localparam int unsigned CIW    = (CR > 1) ? $clog2(CR) : 1;
    localparam int unsigned CJW    = (CC > 1) ? $clog2(CC) : 1;
    localparam int unsigned RW     = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] src_base_q, src_base_d;
    logic [ADDR_WIDTH-1:0] dst_base_q, dst_base_d;
    logic [CIW-1:0]        ci_q, ci_d;
    logic [CJW-1:0]        cj_q, cj_d;
    logic [RW-1:0]         r_q, r_d;

    logic                  addr_valid_q, addr_valid_d;
    logic [ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
    logic                  chunk_last_q, chunk_last_d;
    logic                  pass_last_q, pass_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  run_d;
    logic [ADDR_WIDTH-1:0] row_src, row_tr;
    logic [ADDR_WIDTH-1:0] src_off, tr_off;

    // State, latched pass parameters, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            ci_q         <= '0;
            cj_q         <= '0;
            r_q          <= '0;
            addr_valid_q <= 1'b0;
            src_addr_q   <= '0;
            dst_addr_q   <= '0;
            chunk_last_q <= 1'b0;
            pass_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            src_base_q   <= src_base_d;
            dst_base_q   <= dst_base_d;
            ci_q         <= ci_d;
            cj_q         <= cj_d;
            r_q          <= r_d;
            addr_valid_q <= addr_valid_d;
            src_addr_q   <= src_addr_d;
            dst_addr_q   <= dst_addr_d;
            chunk_last_q <= chunk_last_d;
            pass_last_q  <= pass_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next state, counter advance, and the address pair for the next cycle.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        ci_d       = ci_q;
        cj_d       = cj_q;
        r_d        = r_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d    = S_RUN;
                    mode_d     = mode;
                    src_base_d = src_base;
                    dst_base_d = dst_base;
                    ci_d       = '0;
                    cj_d       = '0;
                    r_d        = '0;
                end
            end
            S_RUN: begin
                // Abort outranks a same-cycle handshake.
                if (abort) begin
                    state_d = S_IDLE;
                    ci_d    = '0;
                    cj_d    = '0;
                    r_d     = '0;
                end else if (addr_valid_q && addr_ready) begin
                    if (pass_last_q) begin
                        state_d = S_DONE;
                        ci_d    = '0;
                        cj_d    = '0;
                        r_d     = '0;
                    end else if (r_q == RW'(CHUNK_SIZE - 1)) begin
                        r_d = '0;
                        if (cj_q == CJW'(CC - 1)) begin
                            cj_d = '0;
                            ci_d = ci_q + CIW'(1);
                        end else begin
                            cj_d = cj_q + CJW'(1);
                        end
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Row index in each layout is {chunk index, in-chunk row}.
        row_src = (ADDR_WIDTH'(ci_d) << LOG_CS) | ADDR_WIDTH'(r_d);
        row_tr  = (ADDR_WIDTH'(cj_d) << LOG_CS) | ADDR_WIDTH'(r_d);
        src_off = (row_src << LOG_SP) + (ADDR_WIDTH'(cj_d) << LOG_CB);
        tr_off  = (row_tr << LOG_TP) + (ADDR_WIDTH'(ci_d) << LOG_CB);

        // Counters only move on a handshake, so a stall re-registers the same pair.
        run_d        = (state_d == S_RUN);
        addr_valid_d = run_d;
        src_addr_d   = run_d ? (src_base_d + src_off) : '0;
        dst_addr_d   = run_d ? (dst_base_d + (mode_d ? tr_off : src_off)) : '0;
        chunk_last_d = run_d && (r_d == RW'(CHUNK_SIZE - 1));
        pass_last_d  = chunk_last_d && (ci_d == CIW'(CR - 1)) && (cj_d == CJW'(CC - 1));
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    assign addr_valid = addr_valid_q;
    assign src_addr   = src_addr_q;
    assign dst_addr   = dst_addr_q;
    assign chunk_last = chunk_last_q;
    assign pass_last  = pass_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_transpose_addr_seq.sv
// Bench for transpose_addr_seq: beat-indexed reference model checked every
// cycle, plus literal address expectations and a 4x8 geometry instance.
module tb_transpose_addr_seq;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int CS    = 4;
    localparam int EB    = 8;
    localparam int NCC   = COLS / CS;
    localparam int TOTAL = (ROWS / CS) * NCC * CS;

    logic        clk = 1'b0;
    logic        rst, start, start_b, mode, abort, addr_ready;
    logic [63:0] src_base, dst_base;

    logic        a_valid, a_cl, a_pl, a_busy, a_done;
    logic [63:0] a_src, a_dst;
    logic        b_valid, b_cl, b_pl, b_busy, b_done;
    logic [63:0] b_src, b_dst;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Handshake records (DUT values captured at each accepted beat).
    logic [63:0] rec_src [0:255];
    logic [63:0] rec_dst [0:255];
    logic        rec_cl  [0:255];
    logic        rec_pl  [0:255];
    int          hs = 0;
    logic [63:0] recb_src [0:63];
    logic [63:0] recb_dst [0:63];
    logic        recb_cl  [0:63];
    logic        recb_pl  [0:63];
    int          hsb = 0;

    // Reference model state.
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_beat   = 0;
    bit          m_mode   = 1'b0;
    logic [63:0] m_sb     = '0;
    logic [63:0] m_db     = '0;

    always #5 clk = ~clk;

    transpose_addr_seq dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_base(src_base), .dst_base(dst_base), .abort(abort),
        .addr_valid(a_valid), .addr_ready(addr_ready),
        .src_addr(a_src), .dst_addr(a_dst),
        .chunk_last(a_cl), .pass_last(a_pl), .busy(a_busy), .done(a_done)
    );

    transpose_addr_seq #(.ARR_ROWS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode),
        .src_base(src_base), .dst_base(dst_base), .abort(abort),
        .addr_valid(b_valid), .addr_ready(addr_ready),
        .src_addr(b_src), .dst_addr(b_dst),
        .chunk_last(b_cl), .pass_last(b_pl), .busy(b_busy), .done(b_done)
    );

    // Beat number -> (ci, cj, r) -> byte addresses, straight from the geometry.
    function automatic logic [63:0] exp_src(int b, logic [63:0] base);
        int r, cj, ci;
        r  = b % CS;
        cj = (b / CS) % NCC;
        ci = b / (CS * NCC);
        return base + 64'((ci * CS + r) * COLS * EB + cj * CS * EB);
    endfunction

    function automatic logic [63:0] exp_dst(int b, logic [63:0] base, bit md);
        int r, cj, ci;
        r  = b % CS;
        cj = (b / CS) % NCC;
        ci = b / (CS * NCC);
        if (md) return base + 64'((cj * CS + r) * ROWS * EB + ci * CS * EB);
        return base + 64'((ci * CS + r) * COLS * EB + cj * CS * EB);
    endfunction

    // Pass-level model: which beat is on offer, or the done pulse.
    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_beat   = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1'b1;
                m_beat   = 0;
                m_mode   = mode;
                m_sb     = src_base;
                m_db     = dst_base;
            end
        end else if (abort) begin
            m_active = 1'b0;
        end else if (addr_ready) begin
            if (m_beat == TOTAL - 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end else begin
                m_beat = m_beat + 1;
            end
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [132:0] act, exp;
        act = {a_valid, a_src, a_dst, a_cl, a_pl, a_busy, a_done};
        if (m_active)
            exp = {1'b1, exp_src(m_beat, m_sb), exp_dst(m_beat, m_db, m_mode),
                   (m_beat % CS) == CS - 1, m_beat == TOTAL - 1, 1'b1, 1'b0};
        else
            exp = {1'b0, 64'h0, 64'h0, 1'b0, 1'b0, m_done, m_done};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cycle_model t=%0t actual=%h expected=%h", $time, act, exp);
        end
    endtask

    // One clock: log the handshake about to happen, then compare after the edge.
    task automatic step();
        if (!rst && !abort && addr_ready && a_valid === 1'b1 && hs < 256) begin
            rec_src[hs] = a_src;
            rec_dst[hs] = a_dst;
            rec_cl[hs]  = a_cl;
            rec_pl[hs]  = a_pl;
            hs++;
        end
        if (!rst && !abort && addr_ready && b_valid === 1'b1 && hsb < 64) begin
            recb_src[hsb] = b_src;
            recb_dst[hsb] = b_dst;
            recb_cl[hsb]  = b_cl;
            recb_pl[hsb]  = b_pl;
            hsb++;
        end
        @(posedge clk);
        #1;
        if (chk_en) compare_model();
    endtask

    // Full pass on dut_a; returns the record index of its beat 0.
    task automatic run_pass(input bit md, input logic [63:0] sb, input logic [63:0] db,
                            input bit rnd, input bit mid_start, output int b0);
        int n;
        b0 = hs;
        mode = md;
        src_base = sb;
        dst_base = db;
        start = 1'b1;
        addr_ready = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (a_done !== 1'b1 && n < 400) begin
            addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mid_start && n == 5) begin
                start    = 1'b1;
                mode     = ~md;
                src_base = 64'h00DE_AD00;
                dst_base = 64'h00BE_EF00;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        chk("pass_done_seen", 64'(a_done), 64'd1);
        step();
    endtask

    initial begin
        int  b, n;
        bit  saw_done;
        rst = 1'b1; start = 1'b0; start_b = 1'b0; mode = 1'b0; abort = 1'b0;
        addr_ready = 1'b0; src_base = '0; dst_base = '0;
        step();
        step();
        chk_en = 1'b1;
        step();
        chk("reset_outputs", 64'({a_valid, a_cl, a_pl, a_busy, a_done}), 64'd0);
        chk("reset_src", a_src, 64'd0);
        rst = 1'b0;
        step();

        // Copy mode, no backpressure.
        run_pass(1'b0, 64'h1000, 64'h2000, 1'b0, 1'b0, b);
        chk("copy_beats", 64'(hs - b), 64'd16);
        chk("copy_b0_src", rec_src[b], 64'h1000);
        chk("copy_b0_dst", rec_dst[b], 64'h2000);
        chk("copy_b1_src", rec_src[b+1], 64'h1040);
        chk("copy_b1_dst", rec_dst[b+1], 64'h2040);
        chk("copy_b4_src", rec_src[b+4], 64'h1020);
        chk("copy_b4_dst", rec_dst[b+4], 64'h2020);
        chk("copy_b3_cl", 64'(rec_cl[b+3]), 64'd1);
        chk("copy_b14_pl", 64'(rec_pl[b+14]), 64'd0);
        chk("copy_b15_pl", 64'(rec_pl[b+15]), 64'd1);

        // Transpose mode, back-to-back with the previous pass.
        run_pass(1'b1, 64'h1000, 64'h2000, 1'b0, 1'b0, b);
        chk("tr_b4_src", rec_src[b+4], 64'h1020);
        chk("tr_b4_dst", rec_dst[b+4], 64'h2100);
        chk("tr_b8_src", rec_src[b+8], 64'h1100);
        chk("tr_b8_dst", rec_dst[b+8], 64'h2020);
        chk("tr_b15_src", rec_src[b+15], 64'h11E0);
        chk("tr_b15_dst", rec_dst[b+15], 64'h21E0);
        chk("tr_b15_last", 64'({rec_cl[b+15], rec_pl[b+15]}), 64'd3);

        // Random backpressure with a stray start mid-pass.
        run_pass(1'b1, 64'h4000, 64'h8000, 1'b1, 1'b1, b);
        chk("rnd_beats", 64'(hs - b), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("rnd_sb_src", rec_src[b+i], exp_src(i, 64'h4000));
            chk("rnd_sb_dst", rec_dst[b+i], exp_dst(i, 64'h8000, 1'b1));
        end

        // Abort on beat 5 while ready is high.
        b = hs;
        mode = 1'b0; src_base = 64'h1000; dst_base = 64'h2000;
        start = 1'b1; addr_ready = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(a_valid === 1'b1 && hs - b == 5) && n < 50) begin
            step();
            n++;
        end
        chk("abort_reached_b5", 64'(hs - b), 64'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", 64'(a_valid), 64'd0);
        chk("abort_busy", 64'(a_busy), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (a_done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        // Abort together with start in IDLE stays idle.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_start", 64'({a_busy, a_valid}), 64'd0);
        step();
        run_pass(1'b0, 64'h1000, 64'h2000, 1'b0, 1'b0, b);
        chk("restart_b0_src", rec_src[b], 64'h1000);
        chk("restart_beats", 64'(hs - b), 64'd16);

        // Address wrap, then reset in the middle of the pass.
        b = hs;
        mode = 1'b0; src_base = 64'hFFFF_FFFF_FFFF_FFC0; dst_base = 64'h0;
        start = 1'b1; addr_ready = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (hs - b < 3 && n < 50) begin
            step();
            n++;
        end
        chk("wrap_b1_src", rec_src[b+1], 64'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_flags", 64'({a_valid, a_cl, a_pl, a_busy, a_done}), 64'd0);
        chk("rst_mid_src", a_src, 64'd0);
        chk("rst_mid_dst", a_dst, 64'd0);
        repeat (3) step();

        // 4x8 geometry, transpose, zero bases.
        b = hsb;
        mode = 1'b1; src_base = 64'h0; dst_base = 64'h0;
        start_b = 1'b1; addr_ready = 1'b1;
        step();
        start_b = 1'b0;
        n = 0;
        while (b_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("geo_done_seen", 64'(b_done), 64'd1);
        chk("geo_beats", 64'(hsb - b), 64'd8);
        chk("geo_b4_src", recb_src[b+4], 64'h20);
        chk("geo_b4_dst", recb_dst[b+4], 64'h80);
        chk("geo_b7_src", recb_src[b+7], 64'hE0);
        chk("geo_b7_dst", recb_dst[b+7], 64'hE0);
        chk("geo_b7_last", 64'({recb_cl[b+7], recb_pl[b+7]}), 64'd3);
        chk("geo_b3_last", 64'({recb_cl[b+3], recb_pl[b+3]}), 64'd2);
        step();
        chk("geo_idle_busy", 64'(b_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/transpose_addr_seq.md
Name: transpose_addr_seq

Overview:
- Sequencer that walks every CHUNK_SIZE x CHUNK_SIZE chunk of an ARR_ROWS x ARR_COLS matrix in memory.
- Emits one source/destination address pair per chunk row over a valid/ready stream, in either copy mode or transpose mode.
- Successor to the single-shot chunk address calculator: it supports rectangular matrices, separate source and destination bases, and self-sequencing with backpressure, abort and a done pulse.
- Sits between the transpose controller and the memory read/write request ports; the in-chunk element transpose is done in the datapath.

Parameters:
- DATA_WIDTH, 64, element width in bits (multiple of 8); EB = DATA_WIDTH/8 bytes per element.
- ADDR_WIDTH, 64, byte address width.
- ARR_ROWS, 8, source matrix rows (power of two, >= CHUNK_SIZE).
- ARR_COLS, 8, source matrix columns (power of two, >= CHUNK_SIZE).
- CHUNK_SIZE, 4, chunk edge in elements (power of two).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a pass; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = transpose; latched on accepted start.
- src_base  input  ADDR_WIDTH  source matrix base; latched on accepted start.
- dst_base  input  ADDR_WIDTH  destination matrix base; latched on accepted start.
- abort  input  1  terminate the current pass.
- addr_valid  output  1  src_addr/dst_addr are valid.
- addr_ready  input  1  consumer accepts the current pair.
- src_addr  output  ADDR_WIDTH  source row address.
- dst_addr  output  ADDR_WIDTH  destination row address.
- chunk_last  output  1  current beat is the last row of its chunk.
- pass_last  output  1  current beat is the final beat of the pass.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when a pass completes normally.

Behaviour:
- Geometry:
  - CR = ARR_ROWS/CHUNK_SIZE, CC = ARR_COLS/CHUNK_SIZE.
  - Counters: chunk row ci, chunk column cj, in-chunk row r.
  - Order: r innermost, then cj, then ci. Total beats = CR*CC*CHUNK_SIZE.
- Addresses:
  - Source pitch SP = ARR_COLS*EB; transposed destination pitch TP = ARR_ROWS*EB.
  - src_addr = src_base + (ci*CHUNK_SIZE + r)*SP + cj*CHUNK_SIZE*EB.
  - Copy mode: dst_addr = dst_base + (ci*CHUNK_SIZE + r)*SP + cj*CHUNK_SIZE*EB.
  - Transpose mode: dst_addr = dst_base + (cj*CHUNK_SIZE + r)*TP + ci*CHUNK_SIZE*EB.
  - All sums are modulo 2^ADDR_WIDTH (wrap, no error flag).
  - Implementation uses shifts only; no multipliers.
- States: IDLE, RUN, DONE.
  - IDLE, start=1, abort=0: latch mode and both bases, clear counters, go to RUN. addr_valid=1 the next cycle with beat 0 (latency 1).
  - RUN: a beat completes on addr_valid & addr_ready.
    - On completion the counters advance and the new addresses are registered for the next cycle.
    - While addr_ready=0, all outputs hold stable.
    - Completing the beat with pass_last=1 goes to DONE.
  - DONE: addr_valid=0, done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; mode/base changes during RUN have no effect.
- abort:
  - In RUN, abort has priority over a same-cycle handshake. Next cycle: IDLE, addr_valid=0, no done pulse, counters cleared.
  - In IDLE, abort together with start leaves the block in IDLE.
  - In DONE, abort is ignored.
- chunk_last = (r == CHUNK_SIZE-1). pass_last = chunk_last & (ci == CR-1) & (cj == CC-1). Both are qualified by addr_valid and are 0 otherwise.
- Degenerate case CR = CC = 1: a pass is CHUNK_SIZE beats.
- Reset: state IDLE; addr_valid, src_addr, dst_addr, chunk_last, pass_last, busy and done all 0; latched registers 0.
  - rst mid-pass wins over all other inputs; next cycle is IDLE with no done pulse.
- Back-to-back passes: start is accepted in the IDLE cycle following DONE, giving a minimum 2-cycle gap between passes.

Test Plan:
- Defaults, mode=0, src_base=0x1000, dst_base=0x2000, addr_ready=1 -> beats 0, 1, 4 give src/dst (0x1000, 0x2000), (0x1040, 0x2040), (0x1020, 0x2020). 16 beats total; pass_last on beat 15; done one cycle after beat 15.
- Defaults, mode=1, same bases -> beat 4 gives (0x1020, 0x2100); beat 8 gives (0x1100, 0x2020); beat 15 gives (0x11E0, 0x21E0) with chunk_last=pass_last=1.
- ARR_ROWS=4, ARR_COLS=8, mode=1, src_base=0, dst_base=0 -> 8 beats; beat 4 gives src 0x20, dst 0x80; beat 7 gives src 0xE0, dst 0xE0.
- Toggle addr_ready randomly at 50% -> addresses hold while stalled; exactly 16 handshakes in scoreboard order; start pulsed during RUN is ignored.
- abort asserted with addr_ready=1 on beat 5 -> next cycle IDLE, addr_valid=0, busy=0, done never asserts. A new start then begins at beat 0.
- src_base=0xFFFF_FFFF_FFFF_FFC0, mode=0 -> beat 1 src_addr = 0x0 (wrap). rst asserted mid-pass -> all outputs 0 the next cycle.
